// File: rtl/sp_pkg.sv
// Shared op-code constants and controller state type for the stack-pointer controller.
package sp_pkg;

  localparam logic [2:0] SP_OP_HOLD    = 3'b000;
  localparam logic [2:0] SP_OP_INC2    = 3'b001;
  localparam logic [2:0] SP_OP_DEC2    = 3'b010;
  localparam logic [2:0] SP_OP_INC1    = 3'b011;
  localparam logic [2:0] SP_OP_DEC1    = 3'b100;
  localparam logic [2:0] SP_OP_LOAD    = 3'b101;
  localparam logic [2:0] SP_OP_SAVE    = 3'b110;
  localparam logic [2:0] SP_OP_RESTORE = 3'b111;

  typedef enum logic {
    NORMAL = 1'b0,
    FAULT  = 1'b1
  } sp_state_e;

endpackage

// File: rtl/sp_ctrl_if.sv
// Operation/status bundle between a stack-pointer controller and its requester.
interface sp_ctrl_if #(
  parameter int ADDR_W = 32
) ();

  logic [2:0]        op;
  logic [ADDR_W-1:0] load_val;
  logic              err_clr;
  logic [ADDR_W-1:0] sp;
  logic              ovf;
  logic              udf;
  logic              fault;
  logic              err_pulse;

  modport master (
    output op, load_val, err_clr,
    input  sp, ovf, udf, fault, err_pulse
  );

  modport slave (
    input  op, load_val, err_clr,
    output sp, ovf, udf, fault, err_pulse
  );

endinterface

// File: rtl/sp_bound_chk.sv
// Range check of a widened SP candidate; bit ADDR_W flags carry (increment) or borrow (decrement).
module sp_bound_chk #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W:0]   cand_i,
  input  logic              dec_i,
  input  logic [ADDR_W-1:0] lo_i,
  input  logic [ADDR_W-1:0] hi_i,
  output logic              ovf_o,
  output logic              udf_o
);

  // Classify the candidate against the legal window [lo_i, hi_i]
  always_comb begin
    ovf_o = 1'b0;
    udf_o = 1'b0;
    if (cand_i[ADDR_W]) begin
      if (dec_i) begin
        ovf_o = 1'b1;
      end else begin
        udf_o = 1'b1;
      end
    end else if (cand_i[ADDR_W-1:0] < lo_i) begin
      ovf_o = 1'b1;
    end else if (cand_i[ADDR_W-1:0] > hi_i) begin
      udf_o = 1'b1;
    end else begin
      ovf_o = 1'b0;
      udf_o = 1'b0;
    end
  end

endmodule

// File: rtl/sp_ctrl.sv
// Bounded stack-pointer controller with sticky error flags and a NORMAL/FAULT state machine.
// Define SP_CTRL_SHADOW_EN to add a one-entry shadow register for ops 110/111.
module sp_ctrl
  import sp_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] SP_RESET = 32'h000F_FFFF,
  parameter logic [ADDR_W-1:0] SP_LIMIT = 32'h0000_0000
) (
  input logic       clk,
  input logic       Rst,
  sp_ctrl_if.slave  bus
);

  localparam logic [ADDR_W:0] ONE_X = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] TWO_X = {{(ADDR_W-1){1'b0}}, 2'b10};

  sp_state_e         state_q, state_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              pulse_q, pulse_d;
  logic [ADDR_W:0]   cand_s;
  logic              dec_s;
  logic              chk_en_s;
  logic              chk_ovf_s;
  logic              chk_udf_s;
  logic              viol_s;
`ifdef SP_CTRL_SHADOW_EN
  logic [ADDR_W-1:0] shadow_q, shadow_d;
`endif

  // Candidate next SP per op; chk_en_s marks ops that would move SP
  always_comb begin
    cand_s   = {1'b0, sp_q};
    dec_s    = 1'b0;
    chk_en_s = 1'b0;
    case (bus.op)
      SP_OP_INC2: begin cand_s = {1'b0, sp_q} + TWO_X; chk_en_s = 1'b1; end
      SP_OP_DEC2: begin cand_s = {1'b0, sp_q} - TWO_X; dec_s = 1'b1; chk_en_s = 1'b1; end
      SP_OP_INC1: begin cand_s = {1'b0, sp_q} + ONE_X; chk_en_s = 1'b1; end
      SP_OP_DEC1: begin cand_s = {1'b0, sp_q} - ONE_X; dec_s = 1'b1; chk_en_s = 1'b1; end
      SP_OP_LOAD: begin cand_s = {1'b0, bus.load_val}; chk_en_s = 1'b1; end
`ifdef SP_CTRL_SHADOW_EN
      SP_OP_RESTORE: begin cand_s = {1'b0, shadow_q}; chk_en_s = 1'b1; end
`endif
      default: begin
        cand_s   = {1'b0, sp_q};
        chk_en_s = 1'b0;
      end
    endcase
  end

  sp_bound_chk #(.ADDR_W(ADDR_W)) u_bound_chk (
    .cand_i (cand_s),
    .dec_i  (dec_s),
    .lo_i   (SP_LIMIT),
    .hi_i   (SP_RESET),
    .ovf_o  (chk_ovf_s),
    .udf_o  (chk_udf_s)
  );

  assign viol_s = chk_en_s & (chk_ovf_s | chk_udf_s);

  // Next-state and datapath decisions; FAULT freezes SP until err_clr
  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    pulse_d = 1'b0;
`ifdef SP_CTRL_SHADOW_EN
    shadow_d = shadow_q;
`endif
    case (state_q)
      NORMAL: begin
        if (viol_s) begin
          state_d = FAULT;
          ovf_d   = ovf_q | chk_ovf_s;
          udf_d   = udf_q | chk_udf_s;
          pulse_d = 1'b1;
        end else if (chk_en_s) begin
          sp_d = cand_s[ADDR_W-1:0];
        end else begin
          sp_d = sp_q;
        end
`ifdef SP_CTRL_SHADOW_EN
        if (bus.op == SP_OP_SAVE) begin
          shadow_d = sp_q;
        end else begin
          shadow_d = shadow_q;
        end
`endif
      end
      FAULT: begin
        if (bus.err_clr) begin
          state_d = NORMAL;
          ovf_d   = 1'b0;
          udf_d   = 1'b0;
        end else begin
          state_d = FAULT;
        end
      end
      default: state_d = NORMAL;
    endcase
  end

  // State register; synchronous reset dominates everything, err_clr included
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q <= NORMAL;
      sp_q    <= SP_RESET;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      pulse_q <= pulse_d;
    end
  end

`ifdef SP_CTRL_SHADOW_EN
  // Shadow copy of SP, empty-stack value out of reset
  always_ff @(posedge clk) begin
    if (Rst) begin
      shadow_q <= SP_RESET;
    end else begin
      shadow_q <= shadow_d;
    end
  end
`endif

  assign bus.sp        = sp_q;
  assign bus.ovf       = ovf_q;
  assign bus.udf       = udf_q;
  assign bus.fault     = (state_q == FAULT);
  assign bus.err_pulse = pulse_q;

endmodule

// File: tb/tb_sp_ctrl.sv
// Randomized and directed bench for sp_ctrl against an arithmetic reference model.
module tb_sp_ctrl;

  localparam longint RST_V = 64'h0000_0000_000F_FFFF;
  localparam longint LIM_V = 64'h0000_0000_0000_0000;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  longint m_sp;
  longint m_shadow;
  bit     m_ovf, m_udf, m_fault, m_pulse;

  sp_ctrl_if #(.ADDR_W(32)) bus ();

  sp_ctrl #(
    .ADDR_W   (32),
    .SP_RESET (32'h000F_FFFF),
    .SP_LIMIT (32'h0000_0000)
  ) dut (
    .clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: SP as a plain integer, moved by the op's delta and checked against the window
  task automatic model(input bit r, input logic [2:0] op, input logic [31:0] lv, input bit clr);
    longint nxt;
    bit     moves;
    m_pulse = 1'b0;
    nxt     = m_sp;
    moves   = 1'b1;
    if (r) begin
      m_sp = RST_V; m_shadow = RST_V;
      m_ovf = 1'b0; m_udf = 1'b0; m_fault = 1'b0;
    end else if (m_fault) begin
      if (clr) begin m_fault = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; end
    end else begin
      case (op)
        3'd1: nxt = m_sp + 2;
        3'd2: nxt = m_sp - 2;
        3'd3: nxt = m_sp + 1;
        3'd4: nxt = m_sp - 1;
        3'd5: nxt = longint'(lv);
`ifdef SP_CTRL_SHADOW_EN
        3'd6: begin moves = 1'b0; m_shadow = m_sp; end
        3'd7: nxt = m_shadow;
`endif
        default: moves = 1'b0;
      endcase
      if (moves) begin
        if (nxt < LIM_V) begin
          m_ovf = 1'b1; m_fault = 1'b1; m_pulse = 1'b1;
        end else if (nxt > RST_V) begin
          m_udf = 1'b1; m_fault = 1'b1; m_pulse = 1'b1;
        end else begin
          m_sp = nxt;
        end
      end
    end
  endtask

  task automatic step(input bit r, input logic [2:0] op, input logic [31:0] lv, input bit clr);
    @(negedge clk);
    rst          = r;
    bus.op       = op;
    bus.load_val = lv;
    bus.err_clr  = clr;
    @(posedge clk);
    #1;
    model(r, op, lv, clr);
    chk("sp", {32'h0, bus.sp}, m_sp);
    chk("ovf", {63'h0, bus.ovf}, {63'h0, m_ovf});
    chk("udf", {63'h0, bus.udf}, {63'h0, m_udf});
    chk("fault", {63'h0, bus.fault}, {63'h0, m_fault});
    chk("err_pulse", {63'h0, bus.err_pulse}, {63'h0, m_pulse});
  endtask

  logic [31:0] lv_r;
  int          sel;

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b0; bus.op = 3'd0; bus.load_val = 32'h0; bus.err_clr = 1'b0;

    step(1'b1, 3'd0, 32'h0, 1'b0);
    chk("reset_sp", {32'h0, bus.sp}, 64'h0000_0000_000F_FFFF);

    // Decrement/increment walk from empty stack
    step(1'b0, 3'd2, 32'h0, 1'b0);
    step(1'b0, 3'd2, 32'h0, 1'b0);
    step(1'b0, 3'd2, 32'h0, 1'b0);
    chk("dec2x3", {32'h0, bus.sp}, 64'h0000_0000_000F_FFF9);
    step(1'b0, 3'd1, 32'h0, 1'b0);
    chk("inc2", {32'h0, bus.sp}, 64'h0000_0000_000F_FFFB);
    step(1'b0, 3'd4, 32'h0, 1'b0);
    chk("dec1", {32'h0, bus.sp}, 64'h0000_0000_000F_FFFA);

    // Increment past empty stack
    step(1'b1, 3'd0, 32'h0, 1'b0);
    step(1'b0, 3'd3, 32'h0, 1'b0);
    chk("udf_flag", {63'h0, bus.udf}, 64'h1);
    chk("udf_pulse", {63'h0, bus.err_pulse}, 64'h1);
    step(1'b0, 3'd2, 32'h0, 1'b0);
    chk("fault_hold", {32'h0, bus.sp}, 64'h0000_0000_000F_FFFF);

    // Borrow below limit, clear, then reach limit exactly
    step(1'b1, 3'd0, 32'h0, 1'b0);
    step(1'b0, 3'd5, 32'h1, 1'b0);
    step(1'b0, 3'd2, 32'h0, 1'b0);
    chk("ovf_flag", {63'h0, bus.ovf}, 64'h1);
    step(1'b0, 3'd4, 32'h0, 1'b1);
    chk("clr_sp", {32'h0, bus.sp}, 64'h1);
    step(1'b0, 3'd4, 32'h0, 1'b0);
    chk("at_limit", {32'h0, bus.sp}, 64'h0);

    // Shadow save/restore
    step(1'b0, 3'd5, 32'h100, 1'b0);
    step(1'b0, 3'd6, 32'h0, 1'b0);
    step(1'b0, 3'd5, 32'h80, 1'b0);
    step(1'b0, 3'd7, 32'h0, 1'b0);
`ifdef SP_CTRL_SHADOW_EN
    chk("restore", {32'h0, bus.sp}, 64'h100);
`else
    chk("restore", {32'h0, bus.sp}, 64'h80);
`endif

    // Out-of-range load faults; reset wins over err_clr
    step(1'b0, 3'd5, 32'h0010_0000, 1'b0);
    chk("load_udf", {63'h0, bus.fault}, 64'h1);
    step(1'b1, 3'd3, 32'h0, 1'b1);
    chk("rst_vs_clr", {63'h0, bus.fault}, 64'h0);

    // Random traffic, loads biased toward both bounds
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: lv_r = $urandom_range(0, 3);
        1: lv_r = 32'h000F_FFFC + $urandom_range(0, 4);
        2: lv_r = $urandom;
        default: lv_r = $urandom_range(0, 32'h0010_0001);
      endcase
      step(($urandom_range(0, 60) == 0), 3'($urandom_range(0, 7)), lv_r,
           ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sp_ctrl.md
SP_CTRL -- requirements
Module: sp_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, bit width of the stack pointer and load data.
REQ-002 Parameter SP_RESET, default 32'h000F_FFFF, value SP takes on reset and upper legal bound (empty stack).
REQ-003 Parameter SP_LIMIT, default 32'h0000_0000, lower legal bound (full stack).
REQ-004 Port clk input 1: clock; reset Rst, synchronous, active-high; clock clk.
REQ-005 Port Rst input 1: synchronous active-high reset.
REQ-006 Port op input 3: operation code; 000 hold, 001 +2, 010 -2, 011 +1, 100 -1, 101 load, 110 shadow save, 111 shadow restore.
REQ-007 Port load_val input ADDR_W: value written to SP on op 101.
REQ-008 Port err_clr input 1: leaves the FAULT state and clears sticky flags.
REQ-009 Port sp output ADDR_W: registered current stack pointer.
REQ-010 Port ovf output 1: sticky flag, an op would have taken SP below SP_LIMIT.
REQ-011 Port udf output 1: sticky flag, an op would have taken SP above SP_RESET.
REQ-012 Port fault output 1: high while the state machine is in FAULT.
REQ-013 Port err_pulse output 1: one-cycle pulse in the cycle after a violating op is sampled.

Function
REQ-014 All state updates SHALL occur on the rising edge of clk; all outputs SHALL be registered.
REQ-015 The candidate next SP SHALL be computed in ADDR_W+1 bits so that carry and borrow are detected without wrap-around.
REQ-016 A candidate < SP_LIMIT or borrow SHALL set ovf; a candidate > SP_RESET or carry SHALL set udf.
REQ-017 On a violation, sp SHALL stay unchanged, the flag SHALL set, err_pulse SHALL assert for one cycle, and the state SHALL become FAULT.
REQ-018 The state machine SHALL have states NORMAL and FAULT; NORMAL->FAULT on a violation; FAULT->NORMAL on err_clr.
REQ-019 In FAULT, every op SHALL be ignored and sp SHALL hold.
REQ-020 err_clr in FAULT SHALL clear ovf, udf and fault on the next edge; the op in that same cycle SHALL be ignored.
REQ-021 err_clr in NORMAL SHALL have no effect; a legal op SHALL execute normally.
REQ-022 Op 101 SHALL load load_val after the same bounds check; an out-of-range load_val SHALL cause a fault.
REQ-023 A result exactly equal to SP_LIMIT or SP_RESET SHALL be legal.
REQ-024 Op 000 and any disabled op SHALL hold sp and never fault.
REQ-025 Latency: sp SHALL reflect an op on the edge at which that op is sampled (one cycle).

Reset
REQ-026 Rst SHALL have priority over all inputs, including mid-fault and err_clr.
REQ-027 On reset: sp=SP_RESET, ovf=0, udf=0, fault=0, err_pulse=0, state=NORMAL, shadow=SP_RESET.

Configuration
REQ-028 Macro SP_CTRL_SHADOW_EN SHALL compile in a one-entry shadow register.
REQ-029 With SP_CTRL_SHADOW_EN: op 110 SHALL copy sp to shadow with sp unchanged; op 111 SHALL copy shadow to sp after the bounds check.
REQ-030 Without SP_CTRL_SHADOW_EN: there SHALL be no shadow register; ops 110 and 111 SHALL act as hold.

Structure
REQ-031 Package sp_pkg SHALL hold the op-code constants (SP_OP_HOLD ... SP_OP_RESTORE) and the state type (NORMAL, FAULT).
REQ-032 The bounds check SHALL be a sub-module sp_bound_chk: a combinational block taking the ADDR_W+1 candidate and the bounds and returning ovf/udf.
REQ-033 Arithmetic, state register and shadow SHALL reside in sp_ctrl.

Verification
REQ-034 Rst=1 one cycle -> sp=32'h000F_FFFF, all flags 0, fault=0.
REQ-035 From reset: op=010 three cycles -> sp=32'h000F_FFF9; then op=001 -> sp=32'h000F_FFFB; then op=100 -> sp=32'h000F_FFFA.
REQ-036 From reset: op=011 -> sp holds 32'h000F_FFFF, udf=1, err_pulse=1 for one cycle, fault=1; op=010 next cycle -> sp unchanged.
REQ-037 Load 32'h1, then op=010 -> ovf=1, sp=1; err_clr=1 with op=100 -> flags 0, sp=1; op=100 -> sp=0, no fault.
REQ-038 SP_CTRL_SHADOW_EN defined: load 32'h100, op=110, load 32'h80, op=111 -> sp=32'h100; macro undefined, same sequence -> sp=32'h80.
REQ-039 In FAULT, Rst=1 together with err_clr=1 -> reset values, state NORMAL.
